// File: rtl/decoder_nb_seq.sv
// Registered one-hot decoder with direct load and a step mode that either wraps or saturates.
// Loads of an index at or beyond OUT_MAX are flagged on err and leave the decoder inactive.
module decoder_nb_seq #(
  parameter int IN_W    = 3,
  parameter int OUT_MAX = 2 ** IN_W,
  parameter int WRAP    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 load,
  input  logic [IN_W-1:0]      in,
  input  logic                 step,
  output logic [2**IN_W-1:0]   out,
  output logic [IN_W-1:0]      idx,
  output logic                 active,
  output logic                 at_last,
  output logic                 wrap_pulse,
  output logic                 err
);

  localparam int OUT_W = 2 ** IN_W;

  // OUT_MAX can equal 2^IN_W, so the legality compare needs one extra bit.
  localparam logic [IN_W:0]   MAX_V  = (IN_W + 1)'(OUT_MAX);
  localparam logic [IN_W-1:0] LAST_V = IN_W'(OUT_MAX - 1);

  logic inLegal;
  logic idxAtLast;

  assign inLegal   = ({1'b0, in} < MAX_V);
  assign idxAtLast = (idx == LAST_V);

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx        <= '0;
      active     <= 1'b0;
      wrap_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clr) begin
        idx    <= '0;
        active <= 1'b0;
      end else if (load) begin
        if (inLegal) begin
          idx    <= in;
          active <= 1'b1;
          err    <= 1'b0;
        end else begin
          active <= 1'b0;
          err    <= 1'b1;
        end
      end else if (step && active) begin
        if (!idxAtLast) begin
          idx <= idx + 1'b1;
        end else if (WRAP != 0) begin
          idx        <= '0;
          wrap_pulse <= 1'b1;
        end
      end
    end
  end

  assign out     = active ? (OUT_W'(1) << idx) : '0;
  assign at_last = active && idxAtLast;

endmodule

// File: tb/tb_decoder_nb_seq.sv
// Directed bench: unit A uses defaults (8 outputs, wrap), unit B uses OUT_MAX=6 with saturation.
module tb_decoder_nb_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       clrA, loadA, stepA;
  logic [2:0] inA;
  logic       clrB, loadB, stepB;
  logic [2:0] inB;

  logic [7:0] outA, outB;
  logic [2:0] idxA, idxB;
  logic       activeA, activeB, atLastA, atLastB, wrapA, wrapB, errA, errB;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  decoder_nb_seq #(.IN_W(3)) dutA (
    .CLK(CLK), .RST(RST), .clr(clrA), .load(loadA), .in(inA), .step(stepA),
    .out(outA), .idx(idxA), .active(activeA), .at_last(atLastA),
    .wrap_pulse(wrapA), .err(errA)
  );

  decoder_nb_seq #(.IN_W(3), .OUT_MAX(6), .WRAP(0)) dutB (
    .CLK(CLK), .RST(RST), .clr(clrB), .load(loadB), .in(inB), .step(stepB),
    .out(outB), .idx(idxB), .active(activeB), .at_last(atLastB),
    .wrap_pulse(wrapB), .err(errB)
  );

  // Drives one unit for a single edge (the other idles), then samples 1 time unit after the edge.
  task automatic applyStimulus(input int unit, input logic c, input logic l,
                               input logic s, input logic [2:0] v);
    clrA = 1'b0; loadA = 1'b0; stepA = 1'b0; inA = 3'd0;
    clrB = 1'b0; loadB = 1'b0; stepB = 1'b0; inB = 3'd0;
    if (unit == 0) begin
      clrA = c; loadA = l; stepA = s; inA = v;
    end else begin
      clrB = c; loadB = l; stepB = s; inB = v;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkUnitA(input string tag, input logic [7:0] o, input logic [2:0] i,
                            input logic a, input logic l, input logic w, input logic e);
    checkOutput({tag, ".out"},     32'(outA),    32'(o));
    checkOutput({tag, ".idx"},     32'(idxA),    32'(i));
    checkOutput({tag, ".active"},  32'(activeA), 32'(a));
    checkOutput({tag, ".at_last"}, 32'(atLastA), 32'(l));
    checkOutput({tag, ".wrap"},    32'(wrapA),   32'(w));
    checkOutput({tag, ".err"},     32'(errA),    32'(e));
  endtask

  task automatic checkUnitB(input string tag, input logic [7:0] o, input logic [2:0] i,
                            input logic a, input logic l, input logic w, input logic e);
    checkOutput({tag, ".out"},     32'(outB),    32'(o));
    checkOutput({tag, ".idx"},     32'(idxB),    32'(i));
    checkOutput({tag, ".active"},  32'(activeB), 32'(a));
    checkOutput({tag, ".at_last"}, 32'(atLastB), 32'(l));
    checkOutput({tag, ".wrap"},    32'(wrapB),   32'(w));
    checkOutput({tag, ".err"},     32'(errB),    32'(e));
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0);
    RST = 1'b0;
    checkUnitA("resetA", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkUnitB("resetB", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(0, 1'b0, 1'b1, 1'b0, 3'd5);
    checkUnitA("load5", 8'h20, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [7:0] expOut;
      expOut = 8'h01 << k;
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 3'(k));
      checkOutput($sformatf("sweep%0d.out", k), 32'(outA), 32'(expOut));
      checkOutput($sformatf("sweep%0d.err", k), 32'(errA), 32'd0);
    end

    applyStimulus(0, 1'b0, 1'b1, 1'b0, 3'd6);
    checkUnitA("wrapLoad6", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 3'd0);
    checkUnitA("wrapStep1", 8'h80, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 3'd0);
    checkUnitA("wrapStep2", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 3'd0);
    checkUnitA("wrapStep3", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkUnitA("idleHold", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus(1, 1'b0, 1'b1, 1'b0, 3'd4);
    checkUnitB("satLoad4", 8'h10, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 3'd0);
    checkUnitB("satStep1", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 3'd0);
    checkUnitB("satStep2", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 3'd0);
    checkUnitB("satStep3", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    applyStimulus(1, 1'b0, 1'b1, 1'b0, 3'd7);
    checkUnitB("illegal7", 8'h00, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 3'd0);
    checkUnitB("stepInactive", 8'h00, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd0);
    checkUnitB("clrKeepsErr", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 3'd2);
    checkUnitB("load2", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 3'd6);
    checkUnitB("illegal6", 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd3);
    checkUnitA("loadBeatsStep", 8'h08, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd5);
    checkUnitA("clrBeatsLoad", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 3'd6);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 3'd0);
    checkUnitA("preReset", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    RST = 1'b1;
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd4);
    RST = 1'b0;
    checkUnitA("midReset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
